// File: rtl/encoder4to2_hs_pkg.sv
// Shared definitions for the 4-to-2 handshake encoder: FSM state encodings
// and the qualification counter width.
package encoder4to2_hs_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL    = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/encoder4to2_hs_sync_2ff.sv
// Double-flop synchroniser for a bank of asynchronous input lines.
// Reusable by any input block that needs clk-domain copies of raw lines.
module sync_2ff #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] meta_p0;
    logic [DATA_W-1:0] sync_p1;

    // first flop may go metastable; second flop gives the settled copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/encoder4to2_hs.sv
// Registered 4-to-2 priority encoder with input synchronisation, debounce
// qualification and a valid/ready output handshake. One code per press.
module encoder4to2_hs
    import encoder4to2_hs_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] D,
    input  logic       E,
    input  logic       RDY,
    output logic [1:0] A,
    output logic       ERR,
    output logic       V
);

    localparam logic [CNT_W-1:0] SC = CNT_W'(STABLE_CYCLES);

    state_t           state;
    logic [3:0]       s;
    logic [3:0]       p;
    logic [CNT_W-1:0] c;
    logic [CNT_W-1:0] c_inc;
    logic [CNT_W-1:0] c_sat;
    logic [1:0]       code_p;
    logic             err_p;

    // Highest set bit wins: D[3] > D[2] > D[1] > D[0].
    function automatic logic [1:0] prio_idx(input logic [3:0] x);
        logic [1:0] r;
        if (x[3])      r = 2'd3;
        else if (x[2]) r = 2'd2;
        else if (x[1]) r = 2'd1;
        else           r = 2'd0;
        return r;
    endfunction

    // More than one bit set: clearing the lowest set bit leaves something.
    function automatic logic multi_hot(input logic [3:0] x);
        return (x & (x - 4'd1)) != 4'd0;
    endfunction

    sync_2ff #(
        .DATA_W (4)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (D),
        .q     (s)
    );

    assign code_p = prio_idx(p);
    assign err_p  = multi_hot(p);
    assign c_inc  = c + CNT_W'(1);
    assign c_sat  = (c_inc > SC) ? SC : c_inc;

    // Press/hold/release sequencer with registered code and valid outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            p     <= '0;
            c     <= '0;
            A     <= '0;
            ERR   <= 1'b0;
            V     <= 1'b0;
        end else if (!E) begin
            // enable low drops any pending code; A/ERR keep their last value
            state <= IDLE;
            c     <= '0;
            V     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s != 4'd0) begin
                        p <= s;
                        c <= CNT_W'(1);
                        if (SC == CNT_W'(1)) begin
                            state <= HOLD;
                            A     <= prio_idx(s);
                            ERR   <= multi_hot(s);
                            V     <= 1'b1;
                        end else begin
                            state <= QUAL;
                        end
                    end
                end
                QUAL: begin
                    if (s == 4'd0) begin
                        state <= IDLE;
                    end else if (s == p) begin
                        c <= c_sat;
                        if (c_inc >= SC) begin
                            state <= HOLD;
                            A     <= code_p;
                            ERR   <= err_p;
                            V     <= 1'b1;
                        end
                    end else begin
                        // a different pattern restarts qualification
                        p <= s;
                        c <= CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (RDY) begin
                        state <= RELEASE;
                        c     <= '0;
                        V     <= 1'b0;
                    end
                end
                RELEASE: begin
                    // lines must read idle for a full window before re-arming
                    if (s == 4'd0) begin
                        c <= c_sat;
                        if (c_inc >= SC) begin
                            state <= IDLE;
                        end
                    end else begin
                        c <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder4to2_hs.sv
// Self-checking bench for encoder4to2_hs: scoreboard of expected codes,
// popped by a monitor on every valid/ready transfer.
module tb_encoder4to2_hs;
    import encoder4to2_hs_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] D = 4'd0;
    logic       E = 1'b1;
    logic       RDY = 1'b0;
    logic [1:0] A, A1;
    logic       ERR, ERR1;
    logic       V, V1;

    int n_checks = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;
    logic [2:0] exp_q[$];

    encoder4to2_hs #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .D(D), .E(E), .RDY(RDY),
        .A(A), .ERR(ERR), .V(V)
    );

    encoder4to2_hs #(.STABLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .D(D), .E(E), .RDY(RDY),
        .A(A1), .ERR(ERR1), .V(V1)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_v(input int max, output int edges);
        bit found;
        found = 1'b0;
        edges = -1;
        for (int i = 1; i <= max; i++) begin
            if (!found) begin
                @(posedge clk);
                #1;
                if (V) begin
                    found = 1'b1;
                    edges = i;
                end
            end
        end
    endtask

    task automatic go_idle();
        D = 4'd0; E = 1'b1; RDY = 1'b0;
        step(12);
    endtask

    task automatic monitor();
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && E && V && RDY) begin
                xfer_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL xfer_unexpected: got A=%0d ERR=%0b, expected no transfer", A, ERR);
                end else begin
                    e = exp_q.pop_front();
                    if ({A, ERR} !== e) begin
                        n_fail++;
                        $display("FAIL xfer_code: got A=%0d ERR=%0b, expected A=%0d ERR=%0b", A, ERR, e[2:1], e[0]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; D = 4'd0; E = 1'b1; RDY = 1'b0;
        step(3);
        n_checks++; if ({V, A, ERR} !== 4'b0000) begin n_fail++; $display("FAIL reset_outputs: got V=%0b A=%0d ERR=%0b, expected 0/0/0", V, A, ERR); end
        n_checks++; if ({V1, A1, ERR1} !== 4'b0000) begin n_fail++; $display("FAIL reset_outputs_sc1: got V=%0b A=%0d ERR=%0b, expected 0/0/0", V1, A1, ERR1); end
        n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d, expected %0d", dut.state, IDLE); end
        rst_n = 1'b1;
        step(3);
    endtask

    task automatic test_single_press();
        int x0, e;
        bit early, saw;
        go_idle();
        x0 = xfer_cnt;
        RDY = 1'b1; D = 4'b0100;
        exp_q.push_back({2'd2, 1'b0});
        early = 1'b0;
        for (int i = 1; i <= 5; i++) begin step(1); if (V) early = 1'b1; end
        n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL press_early_v: got V before edge 6, expected none"); end
        step(1);
        n_checks++; if ({V, A, ERR} !== {1'b1, 2'd2, 1'b0}) begin n_fail++; $display("FAIL press_edge6: got V=%0b A=%0d ERR=%0b, expected 1/2/0", V, A, ERR); end
        step(1);
        n_checks++; if (V !== 1'b0) begin n_fail++; $display("FAIL press_edge7_v: got %0b, expected 0", V); end
        n_checks++; if (xfer_cnt - x0 !== 1) begin n_fail++; $display("FAIL press_xfer: got %0d, expected 1", xfer_cnt - x0); end
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin step(1); if (V) saw = 1'b1; end
        n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL press_no_repeat: got V while held, expected none"); end
        D = 4'd0;
        step(8);
        D = 4'b0100;
        exp_q.push_back({2'd2, 1'b0});
        wait_v(12, e);
        n_checks++; if (e !== 6) begin n_fail++; $display("FAIL press_second_latency: got %0d, expected 6", e); end
        step(2);
        n_checks++; if (xfer_cnt - x0 !== 2) begin n_fail++; $display("FAIL press_second_xfer: got %0d, expected 2", xfer_cnt - x0); end
        RDY = 1'b0;
    endtask

    task automatic test_bounce();
        bit saw;
        go_idle();
        RDY = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            D = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            step(1);
            if (V) saw = 1'b1;
        end
        D = 4'b0100;
        exp_q.push_back({2'd2, 1'b0});
        for (int i = 1; i <= 5; i++) begin step(1); if (V) saw = 1'b1; end
        n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL bounce_spurious_v: got V during bounce, expected none"); end
        step(1);
        n_checks++; if (V !== 1'b1) begin n_fail++; $display("FAIL bounce_latency: got V=%0b at edge 6, expected 1", V); end
        step(1);
        RDY = 1'b0;
    endtask

    task automatic test_multihot_backpressure();
        int x0, e;
        bit bad;
        go_idle();
        x0 = xfer_cnt;
        RDY = 1'b0; D = 4'b1010;
        exp_q.push_back({2'd3, 1'b1});
        wait_v(12, e);
        n_checks++; if (e !== 6) begin n_fail++; $display("FAIL multihot_latency: got %0d, expected 6", e); end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ({V, A, ERR} !== {1'b1, 2'd3, 1'b1}) bad = 1'b1;
            step(1);
        end
        n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL multihot_hold: got unstable V/A/ERR, expected 1/3/1 for 20 cycles"); end
        RDY = 1'b1;
        step(1);
        RDY = 1'b0;
        n_checks++; if (V !== 1'b0) begin n_fail++; $display("FAIL multihot_v_drop: got %0b, expected 0", V); end
        step(10);
        n_checks++; if (xfer_cnt - x0 !== 1) begin n_fail++; $display("FAIL multihot_one_xfer: got %0d, expected 1", xfer_cnt - x0); end
    endtask

    task automatic test_restart();
        int x0, e;
        go_idle();
        x0 = xfer_cnt;
        RDY = 1'b1;
        exp_q.push_back({2'd1, 1'b0});
        D = 4'b0001;
        step(2);
        D = 4'b0010;
        wait_v(15, e);
        n_checks++; if ({V, A, ERR} !== {1'b1, 2'd1, 1'b0}) begin n_fail++; $display("FAIL restart_code: got V=%0b A=%0d ERR=%0b, expected 1/1/0", V, A, ERR); end
        step(10);
        n_checks++; if (xfer_cnt - x0 !== 1) begin n_fail++; $display("FAIL restart_single: got %0d, expected 1", xfer_cnt - x0); end
        RDY = 1'b0;
    endtask

    task automatic test_enable_abort();
        int x0, e;
        go_idle();
        x0 = xfer_cnt;
        D = 4'b0100;
        exp_q.push_back({2'd2, 1'b0});
        wait_v(12, e);
        n_checks++; if (e !== 6) begin n_fail++; $display("FAIL abort_pre_v: got %0d, expected 6", e); end
        E = 1'b0; RDY = 1'b1;
        step(1);
        n_checks++; if (V !== 1'b0) begin n_fail++; $display("FAIL abort_v: got %0b, expected 0", V); end
        n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL abort_state: got %0d, expected %0d", dut.state, IDLE); end
        n_checks++; if (xfer_cnt - x0 !== 0) begin n_fail++; $display("FAIL abort_no_xfer: got %0d, expected 0", xfer_cnt - x0); end
        exp_q.delete();
        E = 1'b1; RDY = 1'b0;
        exp_q.push_back({2'd2, 1'b0});
        wait_v(12, e);
        n_checks++; if (e !== 4) begin n_fail++; $display("FAIL abort_requalify: got %0d, expected 4", e); end
        RDY = 1'b1;
        step(1);
        RDY = 1'b0;
        step(1);
        n_checks++; if (xfer_cnt - x0 !== 1) begin n_fail++; $display("FAIL abort_resume_xfer: got %0d, expected 1", xfer_cnt - x0); end
    endtask

    task automatic test_async_reset();
        int e;
        go_idle();
        D = 4'b0100;
        step(4);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({V, A, ERR} !== 4'b0000) begin n_fail++; $display("FAIL rst_qual_outputs: got V=%0b A=%0d ERR=%0b, expected 0/0/0", V, A, ERR); end
        n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL rst_qual_state: got %0d, expected %0d", dut.state, IDLE); end
        step(1);
        rst_n = 1'b1;
        wait_v(12, e);
        n_checks++; if ({V, A, ERR} !== {1'b1, 2'd2, 1'b0}) begin n_fail++; $display("FAIL rst_hold_pre: got V=%0b A=%0d ERR=%0b, expected 1/2/0", V, A, ERR); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({V, A, ERR} !== 4'b0000) begin n_fail++; $display("FAIL rst_hold_outputs: got V=%0b A=%0d ERR=%0b, expected 0/0/0", V, A, ERR); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(2);
        n_checks++; if (V1 !== 1'b0) begin n_fail++; $display("FAIL sc1_edge2: got V=%0b, expected 0", V1); end
        step(1);
        n_checks++; if ({V1, A1, ERR1} !== {1'b1, 2'd2, 1'b0}) begin n_fail++; $display("FAIL sc1_edge3: got V=%0b A=%0d ERR=%0b, expected 1/2/0", V1, A1, ERR1); end
        n_checks++; if (V !== 1'b0) begin n_fail++; $display("FAIL sc4_edge3: got V=%0b, expected 0", V); end
        D = 4'd0;
        step(4);
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single_press();
        test_bounce();
        test_multihot_backpressure();
        test_restart();
        test_enable_abort();
        test_async_reset();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
